// File: rtl/led_pwm_ctrl.sv
// Avalon-MM LED controller: per-LED enable mask, 8-bit PWM brightness and global blink.
// Duty values are double-buffered so brightness changes only take effect at frame boundaries.
module led_pwm_ctrl #(
   parameter int          NUM_LEDS     = 8,
   parameter logic [15:0] PRESCALE_RST = 16'd195,
   parameter logic [15:0] BLINK_RST    = 16'd250
) (
   input  logic                clk_clk,
   input  logic                reset_reset_n,
   input  logic [2:0]          avs_address,
   input  logic                avs_read,
   output logic [31:0]         avs_readdata,
   input  logic                avs_write,
   input  logic [31:0]         avs_writedata,
   output logic [NUM_LEDS-1:0] leds
);

   localparam logic [2:0] ADDR_CTRL      = 3'd0;
   localparam logic [2:0] ADDR_LED_ON    = 3'd1;
   localparam logic [2:0] ADDR_PRESCALE  = 3'd2;
   localparam logic [2:0] ADDR_BLINK     = 3'd3;
   localparam logic [2:0] ADDR_BRIGHT_LO = 3'd4;
   localparam logic [2:0] ADDR_BRIGHT_HI = 3'd5;
   localparam logic [2:0] ADDR_STATUS    = 3'd6;

   logic [1:0]                ctrl_q, ctrl_d;
   logic [NUM_LEDS-1:0]       led_on_q, led_on_d;
   logic [15:0]               prescale_q, prescale_d;
   logic [15:0]               blink_q, blink_d;
   logic [31:0]               bright_lo_q, bright_lo_d;
   logic [31:0]               bright_hi_q, bright_hi_d;
   logic [15:0]               presc_cnt_q, presc_cnt_d;
   logic [7:0]                pwm_cnt_q, pwm_cnt_d;
   logic [15:0]               frame_cnt_q, frame_cnt_d;
   logic                      blink_phase_q, blink_phase_d;
   logic [NUM_LEDS-1:0][7:0]  shadow_q, shadow_d;
   logic [NUM_LEDS-1:0]       leds_q, leds_d;
   logic [31:0]               readdata_q, readdata_d;

   logic                      wr_ctrl, wr_led_on, wr_prescale, wr_blink, wr_bright_lo, wr_bright_hi;
   logic                      enable, en_rise, tick, frame_end, blink_wrap;
   logic [63:0]               bright_all;
   logic [NUM_LEDS-1:0]       lit;

   assign wr_ctrl      = avs_write && (avs_address == ADDR_CTRL);
   assign wr_led_on    = avs_write && (avs_address == ADDR_LED_ON);
   assign wr_prescale  = avs_write && (avs_address == ADDR_PRESCALE);
   assign wr_blink     = avs_write && (avs_address == ADDR_BLINK);
   assign wr_bright_lo = avs_write && (avs_address == ADDR_BRIGHT_LO);
   assign wr_bright_hi = avs_write && (avs_address == ADDR_BRIGHT_HI);

   always_comb begin
      ctrl_d      = ctrl_q;
      led_on_d    = led_on_q;
      prescale_d  = prescale_q;
      blink_d     = blink_q;
      bright_lo_d = bright_lo_q;
      bright_hi_d = bright_hi_q;
      if (wr_ctrl)      ctrl_d      = avs_writedata[1:0];
      if (wr_led_on)    led_on_d    = avs_writedata[NUM_LEDS-1:0];
      if (wr_prescale)  prescale_d  = avs_writedata[15:0];
      if (wr_blink)     blink_d     = avs_writedata[15:0];
      if (wr_bright_lo) bright_lo_d = avs_writedata;
      if (wr_bright_hi) bright_hi_d = avs_writedata;
   end

   assign enable     = ctrl_q[0];
   assign en_rise    = !ctrl_q[0] && ctrl_d[0];
   assign tick       = enable && (presc_cnt_q == prescale_q);
   assign frame_end  = tick && (pwm_cnt_q == 8'hFF);
   assign blink_wrap = frame_end && (frame_cnt_q == blink_q);
   // Enabling loads the freshest duty values, including one written in the same cycle.
   assign bright_all = {bright_hi_d, bright_lo_d};

   always_comb begin
      presc_cnt_d   = presc_cnt_q;
      pwm_cnt_d     = pwm_cnt_q;
      frame_cnt_d   = frame_cnt_q;
      blink_phase_d = blink_phase_q;
      shadow_d      = shadow_q;

      if (wr_prescale || en_rise)
         presc_cnt_d = '0;
      else if (enable)
         presc_cnt_d = tick ? 16'd0 : presc_cnt_q + 16'd1;

      if (en_rise)
         pwm_cnt_d = '0;
      else if (tick)
         pwm_cnt_d = pwm_cnt_q + 8'd1;

      if (wr_blink)
         frame_cnt_d = '0;
      else if (frame_end)
         frame_cnt_d = blink_wrap ? 16'd0 : frame_cnt_q + 16'd1;

      // Phase is pinned high as soon as blink is switched off, so LEDs reappear at once.
      if (!ctrl_d[1])
         blink_phase_d = 1'b1;
      else if (blink_wrap)
         blink_phase_d = !blink_phase_q;

      if (en_rise || frame_end) begin
         for (int i = 0; i < NUM_LEDS; i++)
            shadow_d[i] = bright_all[i*8 +: 8];
      end
   end

   // Full scale is forced on so a 255 duty has no one-step dark gap per frame.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_LEDS; gi++) begin : g_lit
         assign lit[gi] = (shadow_q[gi] == 8'hFF) || (pwm_cnt_q < shadow_q[gi]);
      end
   endgenerate

   assign leds_d = enable ? (led_on_q & lit & {NUM_LEDS{blink_phase_q}}) : '0;

   always_comb begin
      readdata_d = readdata_q;
      if (avs_read) begin
         unique case (avs_address)
            ADDR_CTRL:      readdata_d = {30'd0, ctrl_q};
            ADDR_LED_ON:    readdata_d = 32'(led_on_q);
            ADDR_PRESCALE:  readdata_d = {16'd0, prescale_q};
            ADDR_BLINK:     readdata_d = {16'd0, blink_q};
            ADDR_BRIGHT_LO: readdata_d = bright_lo_q;
            ADDR_BRIGHT_HI: readdata_d = bright_hi_q;
            ADDR_STATUS:    readdata_d = {frame_cnt_q, 7'd0, blink_phase_q, pwm_cnt_q};
            default:        readdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         ctrl_q        <= '0;
         led_on_q      <= '0;
         prescale_q    <= PRESCALE_RST;
         blink_q       <= BLINK_RST;
         bright_lo_q   <= '0;
         bright_hi_q   <= '0;
         presc_cnt_q   <= '0;
         pwm_cnt_q     <= '0;
         frame_cnt_q   <= '0;
         blink_phase_q <= 1'b1;
         shadow_q      <= '0;
         leds_q        <= '0;
         readdata_q    <= '0;
      end else begin
         ctrl_q        <= ctrl_d;
         led_on_q      <= led_on_d;
         prescale_q    <= prescale_d;
         blink_q       <= blink_d;
         bright_lo_q   <= bright_lo_d;
         bright_hi_q   <= bright_hi_d;
         presc_cnt_q   <= presc_cnt_d;
         pwm_cnt_q     <= pwm_cnt_d;
         frame_cnt_q   <= frame_cnt_d;
         blink_phase_q <= blink_phase_d;
         shadow_q      <= shadow_d;
         leds_q        <= leds_d;
         readdata_q    <= readdata_d;
      end
   end

   assign leds         = leds_q;
   assign avs_readdata = readdata_q;

endmodule

// File: doc/led_pwm_ctrl.md
Name: led_pwm_ctrl

Overview:
- Avalon-MM slave LED controller inside soc_system; its `leds` output is the conduit exported as `custom_leds_0_leds_new_signal[7:0]`.
- The HPS writes registers over the lightweight H2F bridge.
- Provides per-LED on/off masking, 8-bit PWM brightness and a global blink function.
- Runs entirely on the 50 MHz fabric clock.

Parameters:
- NUM_LEDS, 8, number of LED outputs (fixed at 8 in this release; register map assumes 8).
- PRESCALE_RST, 16'd195, reset value of the PWM tick divider (50 MHz / 196 / 256 ≈ 1 kHz frame).
- BLINK_RST, 16'd250, reset value of blink half-period, in PWM frames.

Ports:
- clk_clk  in  1  fabric clock
- reset_reset_n  in  1  asynchronous active-low reset
- avs_address  in  3  word address
- avs_read  in  1  read strobe
- avs_readdata  out  32  read data, valid the cycle after avs_read
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- leds  out  8  LED drive, 1 = lit

Behaviour:

Reset and bus
- Reset is asynchronous assert, synchronous deassert externally.
- All state clears on reset: leds=0, avs_readdata=0, CTRL=0, LED_ON=0, BRIGHT=0, counters=0, blink_phase=1.
- Register map (word address, reset value):
  - 0 CTRL, 0: [0] enable, [1] blink_en.
  - 1 LED_ON, 0: [7:0] per-LED on mask.
  - 2 PRESCALE, PRESCALE_RST: [15:0].
  - 3 BLINK, BLINK_RST: [15:0] half-period in frames.
  - 4 BRIGHT_LO, 0: duty of LED0..3, bytes [7:0]..[31:24].
  - 5 BRIGHT_HI, 0: duty of LED4..7, bytes [7:0]..[31:24].
  - 6 STATUS, read-only: [7:0] pwm_cnt, [8] blink_phase, [31:16] frame_cnt.
  - 7 reserved: reads 0, writes ignored.
- Unused register bits read 0.
- Writes take effect on the clock edge where avs_write=1. No waitrequest.
- Fixed read latency 1: avs_readdata is registered from the address sampled with avs_read. It holds its value when avs_read=0.
- If read and write hit the same address in the same cycle, the read returns the old value.

Prescaler
- presc_cnt counts 0..PRESCALE, then wraps to 0. tick=1 for the single cycle where presc_cnt==PRESCALE.
- PRESCALE=0 gives a tick every cycle.
- Writing PRESCALE clears presc_cnt to 0 on the same edge.

PWM counter
- pwm_cnt (8 bit) increments on tick and wraps 255→0.
- frame_end = tick && pwm_cnt==255.
- Duty shadow registers load from BRIGHT_LO/HI only on frame_end, so duty changes never glitch mid-frame.
- Exception: when CTRL.enable goes 0→1, shadows load immediately and pwm_cnt and presc_cnt clear.

Blink
- frame_cnt (16 bit) increments on frame_end.
- When frame_cnt==BLINK on a frame_end, frame_cnt clears to 0 and blink_phase toggles.
- BLINK=0 toggles blink_phase every frame.
- Writing BLINK clears frame_cnt.
- blink_en=0 holds blink_phase at 1.

LED output (registered, 1-cycle latency from the internal terms)
- leds[i] = enable & LED_ON[i] & blink_phase & lit[i].
- lit[i] = (shadow[i]==8'hFF) ? 1 : (pwm_cnt < shadow[i]).
- shadow=0 gives always off; shadow=255 gives always on (no single-step dropout).

Other rules
- enable=0: leds=0 on the next edge. Counters freeze; blink_phase is held.
- Reset mid-frame: everything returns to reset values asynchronously and leds go to 0 immediately.

Test Plan:
- Reset with a write in flight → leds=0, all registers read their reset values (PRESCALE=195, BLINK=250, STATUS=0x100).
- PRESCALE=0, BRIGHT_LO=0x000080FF, LED_ON=0x07, CTRL=1 → LED0 constant 1; LED1 high for exactly 128 of each 256 cycles; LED2 constant 0; LED3..7 = 0.
- Mid-frame write BRIGHT_LO byte0 0x40→0xC0 (PRESCALE=0) → LED0 duty stays 64 cycles until pwm_cnt wraps, then 192 cycles per frame from the next frame.
- PRESCALE=0, BLINK=1, CTRL=3, LED_ON=0xFF, all BRIGHT=0xFF → leds toggle 0xFF/0x00 every 512 cycles; STATUS[8] tracks the phase.
- Read STATUS on consecutive cycles with PRESCALE=0 → pwm_cnt values differ by 1; a read of address 7 returns 0; readdata appears exactly 1 cycle after avs_read.
- CTRL=0 while LEDs are lit → leds=0 within 1 cycle; re-enable → pwm_cnt restarts at 0 and the new BRIGHT values apply immediately.
